burst_addr_gen: RTL

//  Parametrised burst address generator for the serial MRAM path. It captures a serial burst

---
 rtl/burst_addr_gen.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/burst_addr_gen.sv
// burst_addr_gen: serial burst address generator for the MRAM path.
// Shifts in a burst length and start address MSB first, then shifts out one
// ADDR_WIDTH-bit address per beat (single, incrementing or wrapping burst).
// Ports:
//   clk, rst (async, active-low), en (start, IDLE only), abort (sync),
//   mode_sel (00 single, 01 incr, 10 wrap, 11 incr), len_ser_in, addr_ser_in,
//   addr_sel (mux steer), addr_ser_out, addr_valid, busy, done (1-cycle pulse).
module burst_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned LEN_WIDTH  = 4,
  parameter int unsigned STRIDE     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       abort,
  input  logic [1:0] mode_sel,
  input  logic       len_ser_in,
  input  logic       addr_ser_in,
  output logic       addr_sel,
  output logic       addr_ser_out,
  output logic       addr_valid,
  output logic       busy,
  output logic       done
);

  localparam int unsigned SW   = $clog2(STRIDE);
  localparam int unsigned CW   = ADDR_WIDTH + LEN_WIDTH + SW + 2;
  localparam int unsigned CMAX = (ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH;
  localparam int unsigned BW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [BW-1:0] ADDR_LAST = BW'(ADDR_WIDTH - 1);
  localparam logic [BW-1:0] LEN_LAST  = BW'(LEN_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_LEN, S_LOAD_ADDR, S_CALC, S_SHIFT, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    M_SINGLE, M_INCR, M_WRAP
  } mode_e;

  state_e                 state_q;
  mode_e                  mode_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   beat_q;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [ADDR_WIDTH-1:0]  shift_q;
  logic [BW-1:0]          cnt_q;

  logic [CW-1:0]          base_w, beats_w, span_w, off_w, lin_w, mask_w;
  logic                   wrap_ok;
  logic [ADDR_WIDTH-1:0]  addr_d;

  // Beat address. Arithmetic is done wide so beats*STRIDE cannot overflow
  // before the span check; wrap falls back to incr when the span is not a
  // power of two or exceeds the address space.
  always_comb begin
    base_w  = CW'(base_q);
    beats_w = CW'(len_q) + CW'(1);
    span_w  = beats_w << SW;
    off_w   = CW'(beat_q) << SW;
    lin_w   = base_w + off_w;
    mask_w  = span_w - CW'(1);
    wrap_ok = (mode_q == M_WRAP)
           && ((beats_w & (beats_w - CW'(1))) == '0)
           && (span_w <= (CW'(1) << ADDR_WIDTH));
    if (wrap_ok) begin
      addr_d = ADDR_WIDTH'((base_w & ~mask_w) | (lin_w & mask_w));
    end else begin
      addr_d = lin_w[ADDR_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      mode_q       <= M_SINGLE;
      len_q        <= '0;
      beat_q       <= '0;
      base_q       <= '0;
      shift_q      <= '0;
      cnt_q        <= '0;
      addr_sel     <= 1'b0;
      addr_ser_out <= 1'b0;
      addr_valid   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else if (abort && (state_q != S_IDLE)) begin
      state_q      <= S_IDLE;
      addr_sel     <= 1'b0;
      addr_ser_out <= 1'b0;
      addr_valid   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (en && !abort) begin
            busy   <= 1'b1;
            len_q  <= '0;
            beat_q <= '0;
            cnt_q  <= '0;
            case (mode_sel)
              2'b00:   mode_q <= M_SINGLE;
              2'b10:   mode_q <= M_WRAP;
              default: mode_q <= M_INCR;
            endcase
            state_q <= (mode_sel == 2'b00) ? S_LOAD_ADDR : S_LOAD_LEN;
          end
        end
        S_LOAD_LEN: begin
          len_q <= {len_q[LEN_WIDTH-2:0], len_ser_in};
          if (cnt_q == LEN_LAST) begin
            cnt_q   <= '0;
            state_q <= S_LOAD_ADDR;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_LOAD_ADDR: begin
          base_q <= {base_q[ADDR_WIDTH-2:0], addr_ser_in};
          if (cnt_q == ADDR_LAST) begin
            cnt_q    <= '0;
            addr_sel <= 1'b1;
            state_q  <= S_CALC;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_CALC: begin
          // MSB goes straight to the output register; the rest waits in shift_q.
          addr_ser_out <= addr_d[ADDR_WIDTH-1];
          shift_q      <= {addr_d[ADDR_WIDTH-2:0], 1'b0};
          addr_valid   <= 1'b1;
          cnt_q        <= '0;
          state_q      <= S_SHIFT;
        end
        S_SHIFT: begin
          if (cnt_q == ADDR_LAST) begin
            addr_ser_out <= 1'b0;
            addr_valid   <= 1'b0;
            if (beat_q != len_q) begin
              beat_q  <= beat_q + 1'b1;
              state_q <= S_CALC;
            end else begin
              addr_sel <= 1'b0;
              done     <= 1'b1;
              state_q  <= S_DONE;
            end
          end else begin
            addr_ser_out <= shift_q[ADDR_WIDTH-1];
            shift_q      <= {shift_q[ADDR_WIDTH-2:0], 1'b0};
            cnt_q        <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
